// File: rtl/xor_pkg.sv
// Shared types and limits for the running-XOR engine: packer FSM states and frame-size bounds.
package xor_pkg;

    localparam int unsigned MAX_FRAME_LEN = 255;
    localparam int unsigned XOR_DWIDTH    = 8;

    typedef enum logic [1:0] {
        FILL,
        SEND_CNT,
        SEND_DATA
    } pack_state_t;

endpackage

// File: rtl/frame_buf.sv
// Frame staging storage: one synchronous write port, one asynchronous read port, no reset.
module frame_buf #(
    parameter int unsigned dwidth = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [dwidth-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [dwidth-1:0] o_rdata
);

    logic [dwidth-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/xor_frame_packer.sv
// Buffers one raw byte frame, then emits it downstream as a length byte followed by the payload.
module xor_frame_packer
    import xor_pkg::*;
#(
    parameter int unsigned dwidth  = 8,
    parameter int unsigned MAX_LEN = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [dwidth-1:0] in_data,
    input  logic              in_last,
    input  logic              ofifo_not_full,
    output logic              ofifo_push,
    output logic [dwidth-1:0] odata,
    output logic              ovfl,
    output logic              packer_idle
);

    localparam int unsigned CW = $clog2(MAX_LEN + 1);
    localparam int unsigned AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    if (MAX_LEN < 1 || MAX_LEN > MAX_FRAME_LEN || dwidth < CW) begin : g_param_check
        $error("xor_frame_packer: MAX_LEN must be 1..255 and fit in dwidth");
    end

    pack_state_t       r_state;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_len;
    logic              r_ovfl_seen;
    logic              r_ovfl;

    logic [CW-1:0]     w_max;
    logic              w_full;
    logic              w_xfer;
    logic              w_we;
    logic              w_trunc;
    logic              w_last_rd;
    logic [dwidth-1:0] w_rdata;
    logic [dwidth-1:0] w_odata;

    assign w_max     = CW'(MAX_LEN);
    assign w_full    = (r_wr_cnt == w_max);
    assign w_xfer    = in_valid && (r_state == FILL);
    assign w_we      = w_xfer && !w_full;
    // Truncated if an earlier byte was dropped or this final byte is itself dropped.
    assign w_trunc   = r_ovfl_seen || w_full;
    assign w_last_rd = (r_rd_ptr == r_len - CW'(1));

    frame_buf #(
        .dwidth (dwidth),
        .DEPTH  (MAX_LEN),
        .AW     (AW)
    ) u_frame_buf (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_cnt[AW-1:0]),
        .i_wdata (in_data),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= FILL;
            r_wr_cnt    <= '0;
            r_rd_ptr    <= '0;
            r_len       <= '0;
            r_ovfl_seen <= 1'b0;
            r_ovfl      <= 1'b0;
        end else begin
            r_ovfl <= 1'b0;
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        if (!w_full) begin
                            r_wr_cnt <= r_wr_cnt + CW'(1);
                        end else begin
                            r_ovfl_seen <= 1'b1;
                        end
                        if (in_last) begin
                            r_len       <= w_full ? w_max : r_wr_cnt + CW'(1);
                            r_ovfl      <= w_trunc;
                            r_ovfl_seen <= 1'b0;
                            r_state     <= SEND_CNT;
                        end
                    end
                end
                SEND_CNT: begin
                    if (ofifo_not_full) begin
                        r_rd_ptr <= '0;
                        r_state  <= SEND_DATA;
                    end
                end
                SEND_DATA: begin
                    if (ofifo_not_full) begin
                        if (w_last_rd) begin
                            r_wr_cnt <= '0;
                            r_state  <= FILL;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + CW'(1);
                        end
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    always_comb begin
        w_odata = '0;
        unique case (r_state)
            SEND_CNT:  w_odata = dwidth'(r_len);
            SEND_DATA: w_odata = w_rdata;
            default:   w_odata = '0;
        endcase
    end

    assign in_ready    = (r_state == FILL);
    assign ofifo_push  = (r_state != FILL) && ofifo_not_full;
    assign odata       = w_odata;
    assign ovfl        = r_ovfl;
    assign packer_idle = (r_state == FILL) && (r_wr_cnt == '0);

endmodule
